// File: rtl/cpu_sequencer.sv
// Multi-cycle IF/OF/EX/MA/RW control sequencer for the 32-bit RISC core.
// Owns the phase state, the EX down-counter, the opcode class and the retire count.
module cpu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        of_we,
  output logic        ex_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [4:0] OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_OF   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_RW   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       class_q;
  logic             br_q;
  logic [31:0]      count_q;

  logic [CNT_W-1:0] cnt_load_c;
  logic             is_mem_c;
  logic             rf_class_c;
  logic [1:0]       pc_sel_c;

  // Opcode-derived decodes: EX length from the live opcode, the rest from the latched class
  always_comb begin
    if (opcode == OP_MUL) begin
      cnt_load_c = CNT_W'(MUL_CYCLES - 1);
    end else if ((opcode == OP_DIV) || (opcode == OP_MOD)) begin
      cnt_load_c = CNT_W'(DIV_CYCLES - 1);
    end else begin
      cnt_load_c = '0;
    end
    is_mem_c   = (class_q == OP_LD) || (class_q == OP_ST);
    rf_class_c = class_q inside {[5'd0:5'd4], [5'd6:5'd12], OP_LD, OP_CALL};
    if ((class_q == OP_B) || (class_q == OP_CALL) ||
        (((class_q == OP_BEQ) || (class_q == OP_BGT)) && br_q)) begin
      pc_sel_c = 2'b01;
    end else if (class_q == OP_RET) begin
      pc_sel_c = 2'b10;
    end else begin
      pc_sel_c = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      class_q <= OP_NOP;
      br_q    <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        S_IF: if (imem_ack) state_q <= S_OF;
        S_OF: begin
          class_q <= opcode;
          if (opcode == OP_HALT) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_EX;
            cnt_q   <= cnt_load_c;
          end
        end
        S_EX: begin
          if (cnt_q == '0) begin
            br_q    <= branch_taken;
            state_q <= S_MA;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_MA: if (!is_mem_c || dmem_ack) state_q <= S_RW;
        S_RW: begin
          count_q <= count_q + 32'd1;
          state_q <= S_IF;
        end
        S_HALT: ;
        default: state_q <= S_IF;
      endcase
    end
  end

  // Output decode; everything is forced low while reset is asserted
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    of_we       = 1'b0;
    ex_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    state       = 3'd0;
    halted      = 1'b0;
    instr_count = '0;
    if (!reset) begin
      state       = state_q;
      instr_count = count_q;
      case (state_q)
        S_IF: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_OF: of_we = 1'b1;
        S_EX: ex_we = (cnt_q == '0);
        S_MA: begin
          dmem_req = is_mem_c;
          dmem_we  = (class_q == OP_ST);
        end
        S_RW: begin
          pc_we  = 1'b1;
          rf_we  = rf_class_c;
          pc_sel = pc_sel_c;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: each instruction is expanded into its expected phase list
// (fetch waits, OF, EX length, memory waits, RW) and every cycle is checked against it.
module tb_cpu_sequencer;

  localparam int unsigned MUL_CYCLES = 4;
  localparam int unsigned DIV_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  opcode;
  logic        branch_taken;
  logic        imem_ack;
  logic        dmem_ack;
  logic        imem_req, ir_we, of_we, ex_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       of_we;
    logic       ex_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [2:0] state;
    logic       halted;
  } obs_t;

  obs_t        obs;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_count;

  cpu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .of_we(of_we), .ex_we(ex_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {imem_req, ir_we, of_we, ex_we, dmem_req, dmem_we, rf_we, pc_we,
                pc_sel, state, halted};

  // Called at posedge+1 with inputs already driven; samples, then advances one cycle
  task automatic check_cycle(input obs_t e, input string tag);
    #1;
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: outputs observed %h expected %h", tag, obs, e);
    end
    n_cmp++;
    assert (instr_count === exp_count) else begin
      n_err++;
      $error("FAIL %s count: observed %0d expected %0d", tag, instr_count, exp_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    imem_ack     = 1'($urandom);
    dmem_ack     = 1'($urandom);
    opcode       = 5'($urandom);
    branch_taken = 1'($urandom);
  endtask

  task automatic do_reset();
    obs_t e;
    e = '0;
    reset = 1'b1;
    exp_count = '0;
    noise();
    check_cycle(e, "RST0");
    noise();
    check_cycle(e, "RST1");
    reset = 1'b0;
  endtask

  // abort >= 0 asserts reset on that MA wait cycle of a ld/st
  task automatic run_instr(input logic [4:0] op, input int iw, input int dw,
                           input logic bt, input int abort);
    obs_t e;
    int   exl;
    bit   mem;
    bit   rf;
    exl = (op == 5'd2) ? int'(MUL_CYCLES) :
          ((op == 5'd3) || (op == 5'd4)) ? int'(DIV_CYCLES) : 1;
    mem = (op == 5'd14) || (op == 5'd15);
    rf  = (op <= 5'd4) || ((op >= 5'd6) && (op <= 5'd12)) || (op == 5'd14) || (op == 5'd19);
    for (int i = 0; i <= iw; i++) begin
      noise();
      imem_ack = (i == iw);
      e = '0; e.imem_req = 1'b1; e.ir_we = (i == iw); e.state = 3'd0;
      check_cycle(e, $sformatf("IF op%0d", op));
    end
    noise();
    opcode = op;
    e = '0; e.of_we = 1'b1; e.state = 3'd1;
    check_cycle(e, $sformatf("OF op%0d", op));
    if (op == 5'd31) return;
    for (int i = 0; i < exl; i++) begin
      noise();
      if (i == exl - 1) branch_taken = bt;
      e = '0; e.ex_we = (i == exl - 1); e.state = 3'd2;
      check_cycle(e, $sformatf("EX op%0d c%0d", op, i));
    end
    if (mem) begin
      for (int i = 0; i <= dw; i++) begin
        noise();
        dmem_ack = (i == dw);
        if (i == abort) begin
          reset = 1'b1;
          exp_count = '0;
          e = '0;
          check_cycle(e, "ABORT rst");
          reset = 1'b0;
          noise();
          imem_ack = 1'b0;
          e = '0; e.imem_req = 1'b1; e.state = 3'd0;
          check_cycle(e, "ABORT after");
          return;
        end
        e = '0; e.dmem_req = 1'b1; e.dmem_we = (op == 5'd15); e.state = 3'd3;
        check_cycle(e, $sformatf("MA op%0d w%0d", op, i));
      end
    end else begin
      noise();
      e = '0; e.state = 3'd3;
      check_cycle(e, $sformatf("MA op%0d", op));
    end
    noise();
    e = '0; e.pc_we = 1'b1; e.rf_we = rf; e.state = 3'd4;
    if ((op == 5'd18) || (op == 5'd19) || (((op == 5'd16) || (op == 5'd17)) && bt))
      e.pc_sel = 2'b01;
    else if (op == 5'd20)
      e.pc_sel = 2'b10;
    check_cycle(e, $sformatf("RW op%0d", op));
    exp_count = exp_count + 32'd1;
  endtask

  initial begin
    obs_t e;
    reset = 1'b1; opcode = '0; branch_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_count = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed instructions
    run_instr(5'd0,  0, 0, 1'b0, -1);  // add
    run_instr(5'd2,  0, 0, 1'b0, -1);  // mul
    run_instr(5'd3,  0, 0, 1'b0, -1);  // div
    run_instr(5'd4,  1, 0, 1'b1, -1);  // mod
    run_instr(5'd14, 0, 3, 1'b0, -1);  // ld, 3 wait cycles
    run_instr(5'd15, 0, 0, 1'b0, -1);  // st
    run_instr(5'd16, 0, 0, 1'b1, -1);  // beq taken
    run_instr(5'd16, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(5'd17, 0, 0, 1'b1, -1);  // bgt taken
    run_instr(5'd18, 0, 0, 1'b0, -1);  // b
    run_instr(5'd19, 0, 0, 1'b0, -1);  // call
    run_instr(5'd20, 0, 0, 1'b1, -1);  // ret
    run_instr(5'd5,  0, 0, 1'b0, -1);  // cmp
    run_instr(5'd0,  5, 0, 1'b0, -1);  // add with 5 fetch waits
    run_instr(5'd25, 0, 0, 1'b1, -1);  // undefined acts as nop

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      run_instr(5'($urandom_range(0, 30)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), -1);
    end

    // Reset during a memory wait
    do_reset();
    run_instr(5'd14, 0, 3, 1'b0, 2);
    run_instr(5'd0, 0, 0, 1'b0, -1);

    // Halt and hold
    run_instr(5'd31, 1, 0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      noise();
      e = '0; e.state = 3'd5; e.halted = 1'b1;
      check_cycle(e, $sformatf("HALT c%0d", i));
    end

    // Recovery after reset
    do_reset();
    run_instr(5'd7, 0, 0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 32-bit RISC core. It steps each instruction through the IF, OF, EX, MA and RW phases and generates the latch enables for each phase. It handshakes with instruction and data memory, holds EX for multi-cycle multiply/divide, and selects the next-PC source. The operand-fetch, execute, memory and write-back datapath blocks are enabled only by this block.

## Interface
- MUL_CYCLES, 4: EX duration for mul (opcode 2), ≥1
- DIV_CYCLES, 16: EX duration for div/mod (opcodes 3, 4), ≥1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  5  Instruction[31:27] from IR; sampled only in OF
- branch_taken  in  1  branch-unit flag; sampled on final EX cycle
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- of_we  out  1  latch Op1/Op2/Immx/BranchTarget/Rd
- ex_we  out  1  latch ALU result / flags
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (st)
- rf_we  out  1  register file write
- pc_we  out  1  PC update
- pc_sel  out  2  00 PC+4, 01 BranchTarget, 10 Op1 (ret)
- state  out  3  current phase (debug)
- halted  out  1  core stopped
- instr_count  out  32  retired instructions

## Operation
- States: IF=0, OF=1, EX=2, MA=3, RW=4, HALT=5. Codes 6–7 unused and recover to IF.
- IF: imem_req=1. When imem_ack=1, ir_we=1 in the same cycle and the next state is OF. Otherwise stay in IF.
- OF: of_we=1 for one cycle. Latch opcode into an internal class register. If opcode=5'b11111, go to HALT with of_we still asserted; otherwise go to EX.
- EX: a down-counter is loaded on entry with MUL_CYCLES-1 for mul, DIV_CYCLES-1 for div/mod, and 0 for all other opcodes. The state holds while the counter is nonzero. On the cycle the counter is 0: ex_we=1, branch_taken is latched, and the next state is MA.
- MA for ld (14) and st (15): dmem_req=1, and dmem_we=1 for st only. Hold until dmem_ack=1, then go to RW. MA for all other opcodes: one pass-through cycle with no request.
- RW:
  - pc_we=1 and instr_count increments by 1, wrapping at 2^32.
  - rf_we=1 for opcodes 0–4, 6–12, 14 and 19. It is 0 for cmp (5), nop (13), st, branches and ret.
  - pc_sel=01 for b (18) and call (19), and for beq (16) or bgt (17) when the latched branch_taken is 1.
  - pc_sel=10 for ret (20). Otherwise pc_sel=00.
  - Next state is IF.
- Undefined opcodes 21–30 behave as nop.
- HALT: all enables are 0 and halted=1. The block stays in HALT until reset.
- An ack received while the matching request is low is ignored.

## Timing
- Reset (synchronous, takes priority over everything): state=IF, counter=0, class=nop, branch latch=0, instr_count=0, halted=0.
- Reset asserted mid-instruction (any state, including a pending memory wait) aborts the instruction: no rf_we, no pc_we, no count.
- During the reset cycle all outputs are 0. imem_req rises in the first cycle after reset is released.
- Output decode:
  - ir_we and the MA→RW transition depend on the ack combinationally.
  - All other outputs decode from registered state and class only.
- Latency with zero-wait memory (ack high on the request cycle): ALU op takes 5 cycles; mul takes 4+MUL_CYCLES; div/mod takes 4+DIV_CYCLES.
- Each memory wait cycle adds 1 cycle.
- Exactly one each of ir_we, of_we, ex_we and pc_we is asserted per retired instruction.
- pc_sel is valid only while pc_we=1 and is 00 otherwise.

## Test plan
- Reset, then add (opcode 0) with acks tied high: states 0,1,2,3,4 on consecutive cycles; rf_we=1, pc_sel=00, pc_we=1 on cycle 5; instr_count=1.
- mul with MUL_CYCLES=4: EX lasts exactly 4 cycles and ex_we pulses once on the 4th. div with DIV_CYCLES=16: EX lasts 16 cycles.
- ld with dmem_ack held low for 3 cycles: dmem_req high for 4 cycles, dmem_we=0, rf_we=1 in RW. st: dmem_we=1 during MA, rf_we=0.
- Branch selection, each in its own run:
  - beq with branch_taken=1 in EX gives pc_sel=01; with branch_taken=0 it gives 00.
  - b and call give 01, and call also gives rf_we=1.
  - ret gives pc_sel=10.
  - cmp gives rf_we=0.
- imem_ack low for 5 cycles: imem_req stays high and ir_we stays 0 until the ack arrives. A spurious dmem_ack during EX causes no state change.
- Reset asserted during a MA wait: next state is IF, no pc_we, instr_count unchanged. Opcode 31: HALT reached, halted=1 held for 20 cycles, no further enables.
